// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 joypad: receiver FSM states, prefix bytes,
// button scancodes and small helpers used by the receiver and the decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT0  = 8'hE0;
  localparam logic [7:0] CODE_EXT1  = 8'hE1;

  localparam logic [7:0] CODE_UP     = 8'h75;
  localparam logic [7:0] CODE_DOWN   = 8'h72;
  localparam logic [7:0] CODE_LEFT   = 8'h6B;
  localparam logic [7:0] CODE_RIGHT  = 8'h74;
  localparam logic [7:0] CODE_A      = 8'h22;
  localparam logic [7:0] CODE_B      = 8'h1A;
  localparam logic [7:0] CODE_SELECT = 8'h0D;
  localparam logic [7:0] CODE_START  = 8'h5A;

  // Button vector order: {up, down, left, right, A, B, select, start}
  function automatic logic [7:0] key_mask(input logic [7:0] code);
    logic [7:0] m;
    m = 8'h00;
    case (code)
      CODE_UP:     m = 8'b1000_0000;
      CODE_DOWN:   m = 8'b0100_0000;
      CODE_LEFT:   m = 8'b0010_0000;
      CODE_RIGHT:  m = 8'b0001_0000;
      CODE_A:      m = 8'b0000_1000;
      CODE_B:      m = 8'b0000_0100;
      CODE_SELECT: m = 8'b0000_0010;
      CODE_START:  m = 8'b0000_0001;
      default:     m = 8'h00;
    endcase
    return m;
  endfunction

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises and glitch-filters the device lines,
// deserialises start/8 data/parity/stop frames and aborts stalled frames.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output rx_state_e  state_o
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] filt_cnt_q;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          err_q, err_d;
  logic          fall, din;

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_prev_q <= filt_q;
      if (clk_sync_q[1] == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FILT_MAX) begin
        filt_q     <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;
  assign din  = data_sync_q[1];

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    to_cnt_d     = to_cnt_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    err_d        = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!din) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = din;
          state_d  = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (din && odd_parity_ok(shift_q, parity_q)) begin
            byte_d       = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (to_cnt_q == TO_MAX) begin
      // Saturates in IDLE; a stalled partial frame is abandoned.
      if (state_q != ST_IDLE) begin
        state_d  = ST_IDLE;
        err_d    = 1'b1;
        to_cnt_d = '0;
      end
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      err_q        <= err_d;
    end
  end

  // byte_valid_o is a one-cycle valid with no ready: the consumer must take
  // byte_o in that cycle. frame_err_o is likewise a one-cycle pulse.
  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = err_q;
  assign state_o      = state_q;

endmodule

// File: rtl/ps2_joypad.sv
// PS/2 keyboard to joypad: receives scancodes, tracks break/extended
// prefixes and holds eight button levels driven by make/break codes.
module ps2_joypad
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       A,
  output logic       B,
  output logic       select,
  output logic       start,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       frame_err,
  output logic [1:0] dbg_state_o
);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;
  rx_state_e  rx_state;

  logic [7:0] btn_q, btn_d, code_q, code_d, mask;
  logic       kv_q, kv_d, brk_q, brk_d, ext_q, ext_d;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk_i        (clk_in),
    .rst_i        (rst_in),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_err),
    .state_o      (rx_state)
  );

  assign mask = key_mask(rx_byte);

  always_comb begin
    btn_d  = btn_q;
    code_d = code_q;
    kv_d   = 1'b0;
    brk_d  = brk_q;
    ext_d  = ext_q;
    if (rx_err) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == CODE_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == CODE_EXT0 || rx_byte == CODE_EXT1) begin
        ext_d = 1'b1;
      end else begin
        kv_d   = 1'b1;
        code_d = rx_byte;
        btn_d  = brk_q ? (btn_q & ~mask) : (btn_q | mask);
        brk_d  = 1'b0;
        ext_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      btn_q  <= '0;
      code_q <= '0;
      kv_q   <= 1'b0;
      brk_q  <= 1'b0;
      ext_q  <= 1'b0;
    end else begin
      btn_q  <= btn_d;
      code_q <= code_d;
      kv_q   <= kv_d;
      brk_q  <= brk_d;
      ext_q  <= ext_d;
    end
  end

  assign {up, down, left, right, A, B, select, start} = btn_q;
  assign key_valid   = kv_q;
  assign key_code    = code_q;
  assign frame_err   = rx_err;
  assign dbg_state_o = rx_state;

endmodule

// File: tb/tb_ps2_joypad.sv
// Directed bench for ps2_joypad: a frame table with expected button levels
// and pulse counts, plus hand sequences for latency, timeout and reset.
module tb_ps2_joypad;

  localparam int FL   = 4;
  localparam int TO   = 200;
  localparam int HALF = 10;
  localparam int GAP  = 30;
  localparam int LAT  = 2 + FL + 2;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up, down, left, right, A, B, select, start;
  logic       key_valid, frame_err;
  logic [7:0] key_code;
  logic [1:0] dbg_state;
  logic [7:0] btns;

  int total = 0;
  int bad = 0;
  int kv_cnt = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] btns;
    int         kv;
    int         err;
  } vec_t;
  vec_t tab[$];

  ps2_joypad #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .up          (up),
    .down        (down),
    .left        (left),
    .right       (right),
    .A           (A),
    .B           (B),
    .select      (select),
    .start       (start),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .frame_err   (frame_err),
    .dbg_state_o (dbg_state)
  );

  assign btns = {up, down, left, right, A, B, select, start};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every key_valid pulse must match the oldest expected code.
  always @(negedge clk) begin
    if (!rst_in) begin
      if (key_valid) begin
        kv_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL key_valid_unexpected: got code %0h expected no pulse", key_code);
        end else begin
          check("key_code", {24'd0, key_code}, {24'd0, exp_q.pop_front()});
        end
      end
      if (frame_err) err_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_clk(GAP);
  endtask

  task automatic add(input logic [7:0] code, input bit bp, input bit bs,
                     input logic [7:0] b, input int kv, input int err);
    vec_t v;
    v.code = code; v.bad_par = bp; v.bad_stop = bs;
    v.btns = b; v.kv = kv; v.err = err;
    tab.push_back(v);
  endtask

  task automatic run_frame(input string name, input logic [7:0] code, input bit bp, input bit bs,
                           input logic [7:0] exp_btns, input int exp_kv, input int exp_err);
    int k0, e0;
    k0 = kv_cnt;
    e0 = err_cnt;
    if (exp_kv != 0) exp_q.push_back(code);
    send_frame(code, bp, bs);
    check({name, "_btns"}, {24'd0, btns}, {24'd0, exp_btns});
    check({name, "_kv"}, kv_cnt - k0, exp_kv);
    check({name, "_err"}, err_cnt - e0, exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, e0;
    // Button order {up,down,left,right,A,B,select,start}
    add(8'h22, 0, 0, 8'h08, 1, 0);
    add(8'h1A, 0, 0, 8'h0C, 1, 0);
    add(8'hF0, 0, 0, 8'h0C, 0, 0);
    add(8'h22, 0, 0, 8'h04, 1, 0);
    add(8'hF0, 0, 0, 8'h04, 0, 0);
    add(8'h1A, 0, 0, 8'h00, 1, 0);
    add(8'hE0, 0, 0, 8'h00, 0, 0);
    add(8'h75, 0, 0, 8'h80, 1, 0);
    add(8'hE0, 0, 0, 8'h80, 0, 0);
    add(8'hF0, 0, 0, 8'h80, 0, 0);
    add(8'h75, 0, 0, 8'h00, 1, 0);
    add(8'h1A, 1, 0, 8'h00, 0, 1);
    add(8'hF0, 0, 0, 8'h00, 0, 0);
    add(8'h44, 1, 0, 8'h00, 0, 1);
    add(8'h22, 0, 0, 8'h08, 1, 0);
    add(8'h22, 0, 0, 8'h08, 1, 0);
    add(8'h1C, 0, 0, 8'h08, 1, 0);
    add(8'h72, 0, 0, 8'h48, 1, 0);
    add(8'h6B, 0, 0, 8'h68, 1, 0);
    add(8'h74, 0, 0, 8'h78, 1, 0);
    add(8'h0D, 0, 0, 8'h7A, 1, 0);
    add(8'h5A, 0, 0, 8'h7B, 1, 0);
    add(8'hE1, 0, 0, 8'h7B, 0, 0);
    add(8'hF0, 0, 0, 8'h7B, 0, 0);
    add(8'h6B, 0, 0, 8'h5B, 1, 0);
    add(8'h74, 0, 1, 8'h5B, 0, 1);

    // Reset state
    wait_clk(5);
    check("rst_btns", {24'd0, btns}, 0);
    check("rst_key_code", {24'd0, key_code}, 0);
    check("rst_key_valid", {31'd0, key_valid}, 0);
    check("rst_frame_err", {31'd0, frame_err}, 0);
    check("rst_state", {30'd0, dbg_state}, 0);
    rst_in = 1'b0;
    wait_clk(GAP);

    for (int i = 0; i < tab.size(); i++)
      run_frame($sformatf("row%0d", i), tab[i].code, tab[i].bad_par, tab[i].bad_stop,
                tab[i].btns, tab[i].kv, tab[i].err);
    check("key_code_hold", {24'd0, key_code}, 32'h6B);

    // Reset in the middle of a frame while buttons are held
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_in = 1'b1;
    wait_clk(1);
    rst_in = 1'b0;
    check("midrst_btns", {24'd0, btns}, 0);
    check("midrst_key_code", {24'd0, key_code}, 0);
    check("midrst_key_valid", {31'd0, key_valid}, 0);
    check("midrst_state", {30'd0, dbg_state}, 0);
    wait_clk(GAP);
    run_frame("after_rst", 8'h0D, 0, 0, 8'h02, 1, 0);

    // Stalled partial frame: start plus four data bits, then silence
    k0 = kv_cnt;
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    wait_clk(TO + 50);
    check("timeout_err", err_cnt - e0, 1);
    check("timeout_kv", kv_cnt - k0, 0);
    check("timeout_state", {30'd0, dbg_state}, 0);
    check("timeout_btns", {24'd0, btns}, 32'h02);
    run_frame("after_timeout", 8'h5A, 0, 0, 8'h03, 1, 0);

    // Exact latency: outputs change LAT clocks after ps2_clk falls on the stop bit
    begin
      logic [7:0] c;
      c = 8'h22;
      exp_q.push_back(c);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(c[i]);
      send_bit(~^c);
      ps2_data = 1'b1;
      wait_clk(HALF);
      ps2_clk = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
        @(negedge clk);
        if (k == LAT - 1) begin
          check("lat_pre_A", {31'd0, A}, 0);
          check("lat_pre_kv", {31'd0, key_valid}, 0);
        end else if (k == LAT) begin
          check("lat_A", {31'd0, A}, 1);
          check("lat_kv", {31'd0, key_valid}, 1);
          check("lat_code", {24'd0, key_code}, 32'h22);
          check("lat_btns", {24'd0, btns}, 32'h0B);
        end else if (k == LAT + 1) begin
          check("lat_kv_pulse", {31'd0, key_valid}, 0);
        end
      end
      wait_clk(HALF);
      ps2_clk = 1'b1;
      wait_clk(GAP);
    end

    check("pending_keys", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_joypad.md
PS2_JOYPAD -- requirements
Module: ps2_joypad

Interface
REQ-001 Parameter FILTER_LEN, default 8, number of consecutive equal synchronised ps2_clk samples needed to change the filtered clock.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, clk_in cycles without a filtered falling edge that abort a partial frame.
REQ-003 clk_in  input  1  system clock (100 MHz); single clock domain.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 ps2_clk  input  1  PS/2 device clock, asynchronous to clk_in.
REQ-006 ps2_data  input  1  PS/2 device data, asynchronous to clk_in.
REQ-007 up, down, left, right, A, B, select, start  output  1 each  button state, 1 = key held.
REQ-008 key_valid  output  1  one-cycle pulse when a non-prefix scancode byte is accepted.
REQ-009 key_code  output  8  last accepted non-prefix scancode byte; holds between pulses.
REQ-010 frame_err  output  1  one-cycle pulse on parity error, bad stop bit or timeout.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser.
REQ-012 The filtered clock SHALL change only after FILTER_LEN consecutive identical synchronised samples; a falling edge is filtered 1->0.
REQ-013 Receiver FSM states SHALL be IDLE, DATA, PARITY, STOP; data is sampled on each filtered falling edge.
REQ-014 IDLE->DATA on sampled data 0 (start bit); sampled 1 stays IDLE with no error.
REQ-015 DATA SHALL collect 8 bits LSB first, then go to PARITY.
REQ-016 PARITY SHALL record the bit; the 8 data bits plus parity must have odd parity; then go to STOP.
REQ-017 STOP: bit 1 and parity good -> byte accepted; else byte discarded and frame_err pulsed; both return to IDLE.
REQ-018 A byte-accept strobe SHALL occur 1 cycle after the stop-bit edge detection; button outputs, key_valid and key_code update 1 cycle after that (2 cycles total).
REQ-019 A timeout counter SHALL clear on every filtered falling edge; outside IDLE, reaching TIMEOUT_CYCLES-1 returns to IDLE and pulses frame_err.
REQ-020 Decoder: byte 0xF0 sets flag brk; 0xE0 or 0xE1 sets flag ext; neither produces key_valid.
REQ-021 Any other byte: pulse key_valid, load key_code, apply mapping with level = NOT brk, then clear brk and ext.
REQ-022 Mapping on low byte only, ext ignored: 0x75 up, 0x72 down, 0x6B left, 0x74 right, 0x22 A, 0x1A B, 0x0D select, 0x5A start.
REQ-023 Unmapped codes SHALL leave all buttons unchanged.
REQ-024 Any frame error or timeout SHALL clear brk and ext.
REQ-025 Buttons SHALL be independent; pressing or releasing one never alters another.
REQ-026 Repeated make codes (typematic) SHALL leave a held button at 1 and produce key_valid each time.

Reset
REQ-027 On rst_in all buttons, key_valid, frame_err = 0; key_code = 0x00; brk = ext = 0.
REQ-028 On rst_in the FSM = IDLE, bit count and timeout counter = 0, filtered clock and its edge-detect register = 1.
REQ-029 Reset mid-frame SHALL discard the partial byte; the first complete frame after reset decodes normally.

Structure
REQ-030 Shared package ps2_pkg SHALL hold the FSM state encodings, prefix constants 0xF0/0xE0/0xE1 and the eight mapping scancodes.
REQ-031 One sub-module ps2_rx SHALL contain sync, filter, FSM and timeout, and output byte, strobe and error; ps2_joypad holds the decoder and button registers.

Verification
REQ-032 Frame 0x22 with correct parity -> A=1 exactly 2 cycles after the stop edge; key_valid pulse with key_code=0x22; other buttons 0.
REQ-033 E0 75, then E0 F0 75 -> up 1 after the first 75, 0 after the second; no key_valid on the E0 or F0 bytes.
REQ-034 Frame 0x1A with bad parity -> B stays 0, frame_err one-cycle pulse, key_valid 0.
REQ-035 Start plus 4 data bits, then ps2_clk idle for TIMEOUT_CYCLES -> frame_err pulse; following frame 0x5A -> start=1.
REQ-036 Press 0x1A, press 0x22, then F0 22 -> B=1, A=0.
REQ-037 A held, rst_in asserted mid-frame for 1 cycle -> all outputs 0; next frame 0x0D -> select=1.
